// File: rtl/sum_uart_reporter.sv
// Captures the solver total on the sum_done rising edge, converts it to decimal with an
// iterative double-dabble, and streams "<digits>\r\n" over an 8N1 UART. Define REPORT_HEX_EN to append " 0x" + 16 hex digits.
module sum_uart_reporter #(
  parameter int SUM_WIDTH    = 64,
  parameter int CLKS_PER_BIT = 217
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SUM_WIDTH-1:0] sum_in,
  input  logic                 sum_done,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 report_done
);

  localparam int DIGITS = 20;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(SUM_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(SUM_WIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CONVERT, S_SKIP, S_SEND, S_HEX, S_CR, S_LF, S_DRAIN, S_FINISH
  } state_t;

  state_t state, next_state;

  logic                 done_q;
  logic                 start_edge;
  logic [SUM_WIDTH-1:0] sum_sh;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     conv_cnt;
  logic [4:0]           nib_idx;
  logic [6:0]           nib_base;
  logic [3:0]           cur_nib;

  // Transmitter. Handshake: the FSM raises tx_load with tx_byte only while tx_ready is
  // high; tx_ready is high when the line is idle or in the last cycle of a stop bit, so a
  // load in that cycle puts the next start bit directly after the stop bit.
  logic                 tx_load;
  logic [7:0]           tx_byte;
  logic                 tx_ready;
  logic                 frame_end;
  logic                 tx_active;
  logic                 tx_reg;
  logic [8:0]           tx_shift;
  logic [3:0]           bit_idx;
  logic [BAUD_W-1:0]    baud_cnt;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign start_edge = sum_done & ~done_q;
  assign bcd_adj    = add3(bcd);
  assign nib_base   = {nib_idx, 2'b00};
  assign cur_nib    = bcd[nib_base +: 4];
  assign frame_end  = tx_active && (bit_idx == 4'd9) && (baud_cnt == BAUD_LAST);
  assign tx_ready   = !tx_active || frame_end;

`ifdef REPORT_HEX_EN
  logic [63:0] sum_cap;
  logic [4:0]  hex_cnt;
  logic [3:0]  hex_pos;
  logic [3:0]  hex_nib;
  logic [7:0]  hex_byte;

  // hex_cnt 0..2 send " 0x", 3..18 send nibbles 15 down to 0 of the captured sum.
  assign hex_pos = 4'(5'd18 - hex_cnt);
  assign hex_nib = sum_cap[{hex_pos, 2'b00} +: 4];

  always_comb begin
    hex_byte = 8'h20;
    case (hex_cnt)
      5'd0:    hex_byte = 8'h20;
      5'd1:    hex_byte = 8'h30;
      5'd2:    hex_byte = 8'h78;
      default: hex_byte = (hex_nib < 4'd10) ? (8'h30 + {4'h0, hex_nib})
                                             : (8'h37 + {4'h0, hex_nib});
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_cap <= '0;
      hex_cnt <= '0;
    end else if (state == S_IDLE && start_edge) begin
      sum_cap <= 64'(sum_in);
      hex_cnt <= '0;
    end else if (state == S_HEX && tx_ready) begin
      hex_cnt <= hex_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_load    = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      S_IDLE:    if (start_edge) next_state = S_CONVERT;
      S_CONVERT: if (conv_cnt == CONV_LAST) next_state = S_SKIP;
      // The least significant nibble is never skipped so a zero sum still prints "0".
      S_SKIP:    if (nib_idx == 5'd0 || cur_nib != 4'd0) next_state = S_SEND;
      S_SEND: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          tx_byte = 8'h30 + {4'h0, cur_nib};
          if (nib_idx == 5'd0) begin
`ifdef REPORT_HEX_EN
            next_state = S_HEX;
`else
            next_state = S_CR;
`endif
          end
        end
      end
`ifdef REPORT_HEX_EN
      S_HEX: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          tx_byte = hex_byte;
          if (hex_cnt == 5'd18) next_state = S_CR;
        end
      end
`endif
      S_CR: begin
        if (tx_ready) begin
          tx_load    = 1'b1;
          tx_byte    = 8'h0D;
          next_state = S_LF;
        end
      end
      S_LF: begin
        if (tx_ready) begin
          tx_load    = 1'b1;
          tx_byte    = 8'h0A;
          next_state = S_DRAIN;
        end
      end
      S_DRAIN:   if (frame_end) next_state = S_FINISH;
      S_FINISH:  next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      sum_sh   <= '0;
      bcd      <= '0;
      conv_cnt <= '0;
      nib_idx  <= '0;
    end else begin
      done_q <= sum_done;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            sum_sh   <= sum_in;
            bcd      <= '0;
            conv_cnt <= '0;
            nib_idx  <= 5'(DIGITS - 1);
          end
        end
        S_CONVERT: begin
          bcd      <= (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, sum_sh[SUM_WIDTH-1]};
          sum_sh   <= sum_sh << 1;
          conv_cnt <= conv_cnt + 1'b1;
        end
        S_SKIP: if (nib_idx != 5'd0 && cur_nib == 4'd0) nib_idx <= nib_idx - 1'b1;
        S_SEND: if (tx_ready && nib_idx != 5'd0) nib_idx <= nib_idx - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_active <= 1'b0;
      tx_reg    <= 1'b1;
      tx_shift  <= '1;
      bit_idx   <= '0;
      baud_cnt  <= '0;
    end else if (tx_load) begin
      tx_active <= 1'b1;
      tx_reg    <= 1'b0;
      tx_shift  <= {1'b1, tx_byte};
      bit_idx   <= '0;
      baud_cnt  <= '0;
    end else if (tx_active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          tx_active <= 1'b0;
          tx_reg    <= 1'b1;
        end else begin
          bit_idx  <= bit_idx + 1'b1;
          tx_reg   <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign uart_tx     = tx_reg;
  assign busy        = (state != S_IDLE) && (state != S_FINISH);
  assign report_done = (state == S_FINISH);

endmodule

// File: tb/tb_sum_uart_reporter.sv
// Bench for sum_uart_reporter: random and directed sums, a UART receiver monitor that
// compares every decoded byte against a decimal/hex text model, plus reset and timing cases.
`timescale 1ns/1ps
module tb_sum_uart_reporter;

  localparam int CLKS      = 4;
  localparam int CLKS_SLOW = 217;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] sum_in = '0;
  logic        sum_done = 1'b0;
  logic        uart_tx, busy, report_done;
  logic [63:0] sum_in_s = '0;
  logic        sum_done_s = 1'b0;
  logic        tx_s, busy_s, done_s;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         exp_done_q[$];

  int   epoch = 0;
  int   msg_epoch = -1;
  int   msg_start = 0;
  int   msg_frames = 0;
  bit   in_msg = 1'b0;
  int   done_count = 0;
  logic prev_done = 1'b0;
  int   slow_low = 0;

  logic [7:0] rx_b;
  logic [7:0] rx_exp;
  int         rx_ep;
  logic       rx_ok;

  sum_uart_reporter #(.SUM_WIDTH(64), .CLKS_PER_BIT(CLKS)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_done(sum_done),
    .uart_tx(uart_tx), .busy(busy), .report_done(report_done)
  );

  sum_uart_reporter #(.SUM_WIDTH(64), .CLKS_PER_BIT(CLKS_SLOW)) dut_s (
    .clk(clk), .rst(rst), .sum_in(sum_in_s), .sum_done(sum_done_s),
    .uart_tx(tx_s), .busy(busy_s), .report_done(done_s)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] got);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, got, cyc);
  endtask

  // Reference text: decimal by repeated division, optional hex, then CR LF.
  function automatic byte_q_t build_msg(input logic [63:0] v);
    byte_q_t     q;
    logic [63:0] r;
    logic [3:0]  n;
    r = v;
    do begin
      q.push_front(8'h30 + 8'(r % 64'd10));
      r = r / 64'd10;
    end while (r != 64'd0);
`ifdef REPORT_HEX_EN
    q.push_back(8'h20);
    q.push_back(8'h30);
    q.push_back(8'h78);
    for (int i = 15; i >= 0; i--) begin
      n = v[4*i +: 4];
      q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
    end
`endif
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic push_expected(input logic [63:0] v);
    byte_q_t q;
    q = build_msg(v);
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  // driver tasks
  task automatic issue(input logic [63:0] v);
    @(negedge clk);
    sum_done = 1'b0;
    sum_in   = v;
    @(negedge clk);
    sum_done = 1'b1;
    push_expected(v);
  endtask

  task automatic wait_done(input int n, input int budget);
    int t;
    t = 0;
    while (done_count < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("report_done_seen", 64'(done_count >= n), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // UART receiver monitor: samples mid-bit, pops the expected byte and compares.
  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && rst === 1'b0) begin
        rx_ep = epoch;
        if (!in_msg || msg_epoch != rx_ep) begin
          in_msg     = 1'b1;
          msg_epoch  = rx_ep;
          msg_start  = cyc;
          msg_frames = 0;
        end
        msg_frames++;
        repeat (CLKS / 2) @(negedge clk);
        rx_ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKS) @(negedge clk);
          rx_b[i] = uart_tx;
        end
        repeat (CLKS) @(negedge clk);
        rx_ok = rx_ok && (uart_tx === 1'b1);
        if (rx_ep == epoch) begin
          check("rx_framing", 64'(rx_ok), 64'd1);
          if (exp_q.size() == 0) begin
            fail_now("rx_unexpected_byte", 64'(rx_b));
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_byte", 64'(rx_b), 64'(rx_exp));
            if (rx_exp == 8'h0A) begin
              in_msg = 1'b0;
              exp_done_q.push_back(msg_start + msg_frames * 10 * CLKS);
            end
          end
        end
      end
    end
  end

  // report_done monitor: timing relative to the first start bit, single-cycle, busy low.
  always @(negedge clk) begin
    if (report_done === 1'b1) begin
      check("done_single_cycle", 64'(prev_done), 64'd0);
      check("busy_low_at_done", 64'(busy), 64'd0);
      if (exp_done_q.size() == 0) fail_now("unexpected_report_done", 64'(cyc));
      else check("done_timing", 64'(cyc), 64'(exp_done_q.pop_front()));
      done_count++;
    end
    prev_done = report_done;
    if (tx_s === 1'b0) slow_low++;
  end

  initial begin : main
    int          bad;
    int          t;
    int          n;
    int          t0;
    int          base;
    int          exp_low;
    logic [63:0] v;
    logic [7:0]  b;
    byte_q_t     slow_msg;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_uart_tx", 64'(uart_tx), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_report_done", 64'(report_done), 64'd0);
    rst = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || report_done !== 1'b0) bad++;
    end
    check("idle_after_reset", 64'(bad), 64'd0);

    n = 0;
    issue(64'd32976912643);         n++; wait_done(n, 3000);
    issue(64'd0);                   n++; wait_done(n, 3000);
    issue(64'hFFFF_FFFF_FFFF_FFFF); n++; wait_done(n, 3000);
    issue(64'd1);                   n++; wait_done(n, 3000);
    issue(64'd10000000000000000000); n++; wait_done(n, 3000);
    issue(64'd9);                   n++; wait_done(n, 3000);

    for (int k = 0; k < 8; k++) begin
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      issue(v); n++; wait_done(n, 3000);
    end

    // sum_done held high: a single report
    issue({$urandom, $urandom});
    n++;
    repeat (5000) @(negedge clk);
    check("held_high_one_report", 64'(done_count), 64'(n));
    check("held_high_queue_drained", 64'(exp_q.size()), 64'd0);

    // second rising edge while busy is dropped
    issue(64'd123456789012345);
    n++;
    repeat (200) @(negedge clk);
    check("busy_mid_report", 64'(busy), 64'd1);
    sum_done = 1'b0;
    sum_in   = 64'd777;
    @(negedge clk);
    sum_done = 1'b1;
    wait_done(n, 3000);
    repeat (1500) @(negedge clk);
    check("edge_while_busy_ignored", 64'(done_count), 64'(n));

    // reset during the 3rd data bit of the 2nd frame
    issue(64'd987654321);
    t = 0;
    while (!(in_msg && msg_epoch == epoch) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reset_case_started", 64'(t < 2000), 64'd1);
    wait_until(msg_start + 40 + 13);
    rst      = 1'b1;
    sum_done = 1'b0;
    epoch++;
    exp_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    check("midreset_uart_tx", 64'(uart_tx), 64'd1);
    check("midreset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no_start_after_reset", 64'(bad), 64'd0);
    check("no_done_after_reset", 64'(done_count), 64'(n));
    issue(64'd55555);
    n++;
    wait_done(n, 3000);

    // rst together with a rising edge: no capture; the still-high level reports later
    @(negedge clk);
    sum_done = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    sum_done = 1'b1;
    sum_in   = 64'd11111;
    @(negedge clk);
    check("rst_wins_busy", 64'(busy), 64'd0);
    rst    = 1'b0;
    sum_in = 64'd42424242;
    push_expected(64'd42424242);
    n++;
    @(negedge clk);
    sum_in = 64'd99;
    wait_done(n, 3000);
    sum_done = 1'b0;

    // slow instance: real baud divisor
    slow_msg = build_msg(64'd7);
    exp_low = 0;
    foreach (slow_msg[i]) exp_low += (9 - $countones(slow_msg[i])) * CLKS_SLOW;
    @(negedge clk);
    sum_in_s   = 64'd7;
    sum_done_s = 1'b1;
    t = 0;
    while (tx_s !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("slow_start_seen", 64'(t < 1000), 64'd1);
    t0 = cyc;
    for (int f = 0; f < slow_msg.size(); f++) begin
      base = t0 + f * 10 * CLKS_SLOW;
      wait_until(base + CLKS_SLOW / 2);
      check("slow_start_bit", 64'(tx_s), 64'd0);
      for (int i = 0; i < 8; i++) begin
        wait_until(base + CLKS_SLOW / 2 + (i + 1) * CLKS_SLOW);
        b[i] = tx_s;
      end
      check("slow_byte", 64'(b), 64'(slow_msg[f]));
      wait_until(base + CLKS_SLOW / 2 + 9 * CLKS_SLOW);
      check("slow_stop_bit", 64'(tx_s), 64'd1);
      wait_until(base + 10 * CLKS_SLOW - 1);
      check("slow_stop_last_cycle", 64'(tx_s), 64'd1);
      if (f < slow_msg.size() - 1) begin
        wait_until(base + 10 * CLKS_SLOW);
        check("slow_back_to_back", 64'(tx_s), 64'd0);
      end
    end
    wait_until(t0 + slow_msg.size() * 10 * CLKS_SLOW - 1);
    check("slow_done_not_early", 64'(done_s), 64'd0);
    wait_until(t0 + slow_msg.size() * 10 * CLKS_SLOW);
    check("slow_done_pulse", 64'(done_s), 64'd1);
    check("slow_busy_low", 64'(busy_s), 64'd0);
    repeat (100) @(negedge clk);
    check("slow_low_cycles", 64'(slow_low), 64'(exp_low));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
